// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: post-reset flush
// sequence, load-use stalls, branch/jump/jr squashing, EX forwarding and perf counters.
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic [4:0]       EX_Rs,
  input  logic [4:0]       EX_Rt,
  input  logic             EX_MemRead,
  input  logic             EX_Jr,
  input  logic [4:0]       EX_WriteReg,
  input  logic             MEM_RegWrite,
  input  logic [4:0]       MEM_WriteReg,
  input  logic             WB_RegWrite,
  input  logic [4:0]       WB_WriteReg,
  input  logic             M_PCSrc,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             InitDone,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [0:0]       S_INIT    = 1'b0;
  localparam logic [0:0]       S_RUN     = 1'b1;
  localparam logic [3:0]       INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [0:0]       r_state;
  logic [3:0]       r_init_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_lu;
  logic       w_stall_inc;
  logic       w_flush_inc;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // MEM result is newer than WB, so it wins; $0 is hardwired and never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic mem_we, input logic [4:0] mem_rd,
                                         input logic wb_we,  input logic [4:0] wb_rd);
    if (mem_we && mem_rd != 5'd0 && mem_rd == src)    return 2'b10;
    else if (wb_we && wb_rd != 5'd0 && wb_rd == src)  return 2'b01;
    else                                              return 2'b00;
  endfunction

  assign w_fwd_a = fwd_sel(EX_Rs, MEM_RegWrite, MEM_WriteReg, WB_RegWrite, WB_WriteReg);
  assign w_fwd_b = fwd_sel(EX_Rt, MEM_RegWrite, MEM_WriteReg, WB_RegWrite, WB_WriteReg);

  assign w_lu = EX_MemRead && (EX_WriteReg != 5'd0) &&
                ((ID_UsesRs && ID_Rs == EX_WriteReg) || (ID_UsesRt && ID_Rt == EX_WriteReg));

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    PCWrite     = 1'b0;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b1;
    IDEX_Flush  = 1'b1;
    EXMEM_Flush = 1'b1;
    ForwardA    = 2'b00;
    ForwardB    = 2'b00;
    InitDone    = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (r_state == S_RUN) begin
      InitDone    = 1'b1;
      ForwardA    = w_fwd_a;
      ForwardB    = w_fwd_b;
      PCWrite     = 1'b1;
      IFID_Flush  = 1'b0;
      IDEX_Flush  = 1'b0;
      EXMEM_Flush = 1'b0;
      if (M_PCSrc) begin
        IFID_Flush  = 1'b1;
        IDEX_Flush  = 1'b1;
        EXMEM_Flush = 1'b1;
        w_flush_inc = 1'b1;
      end else if (EX_Jr) begin
        IFID_Flush  = 1'b1;
        IDEX_Flush  = 1'b1;
        w_flush_inc = 1'b1;
      end else if (w_lu) begin
        // Hold PC and IF/ID, inject a bubble into EX; the jump retries next cycle.
        PCWrite     = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Flush  = 1'b1;
        w_stall_inc = 1'b1;
      end else if (ID_Jump) begin
        IFID_Flush  = 1'b1;
        w_flush_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      r_state     <= S_INIT;
      r_init_cnt  <= 4'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_state == S_INIT) begin
        r_init_cnt <= r_init_cnt + 4'd1;
        if (r_init_cnt == INIT_LAST) r_state <= S_RUN;
      end
      if (w_stall_inc && r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a driver pushes expected outputs from a
// rule-level model into a queue, a monitor pops and compares each cycle.
module tb_pipeline_hazard_ctrl;

  localparam int INIT_CYCLES = 4;
  localparam int CNT_W       = 16;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [4:0]       ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_WriteReg, MEM_WriteReg, WB_WriteReg;
  logic             ID_UsesRs, ID_UsesRt, ID_Jump, EX_MemRead, EX_Jr;
  logic             MEM_RegWrite, WB_RegWrite, M_PCSrc;
  logic             PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, InitDone;
  logic [1:0]       ForwardA, ForwardB;
  logic [CNT_W-1:0] StallCount, FlushCount;

  typedef struct packed {
    logic       reset;
    logic [4:0] id_rs, id_rt;
    logic       uses_rs, uses_rt, jump;
    logic [4:0] ex_rs, ex_rt;
    logic       ex_memread, ex_jr;
    logic [4:0] ex_wr;
    logic       mem_rw;
    logic [4:0] mem_wr;
    logic       wb_rw;
    logic [4:0] wb_wr;
    logic       pcsrc;
  } stim_t;

  typedef struct {
    string      tag;
    logic       pcw, ifidw, ifidf, idexf, exmemf, done;
    logic [1:0] fa, fb;
    int         stall, flush;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: cycles since the last reset edge and plain integer counters.
  bit m_known = 1'b0;
  int m_cyc   = 0;
  int m_stall = 0;
  int m_flush = 0;

  pipeline_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_Jump(ID_Jump), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_MemRead(EX_MemRead),
    .EX_Jr(EX_Jr), .EX_WriteReg(EX_WriteReg), .MEM_RegWrite(MEM_RegWrite),
    .MEM_WriteReg(MEM_WriteReg), .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
    .M_PCSrc(M_PCSrc), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .InitDone(InitDone),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 Clk = ~Clk;

  function automatic logic [1:0] ref_fwd(input stim_t s, input logic [4:0] src);
    if (s.mem_rw && s.mem_wr != 0 && s.mem_wr == src) return 2'b10;
    if (s.wb_rw && s.wb_wr != 0 && s.wb_wr == src)    return 2'b01;
    return 2'b00;
  endfunction

  task automatic predict(input stim_t s, input string tag, output exp_t e,
                         output bit s_inc, output bit f_inc);
    bit lu;
    lu = s.ex_memread && s.ex_wr != 0 &&
         ((s.uses_rs && s.id_rs == s.ex_wr) || (s.uses_rt && s.id_rt == s.ex_wr));
    e.tag = tag; e.stall = m_stall; e.flush = m_flush;
    s_inc = 0; f_inc = 0;
    if (m_cyc < INIT_CYCLES) begin
      e.pcw = 0; e.ifidw = 1; e.ifidf = 1; e.idexf = 1; e.exmemf = 1;
      e.fa = 0; e.fb = 0; e.done = 0;
    end else begin
      e.done = 1; e.fa = ref_fwd(s, s.ex_rs); e.fb = ref_fwd(s, s.ex_rt);
      e.pcw = 1; e.ifidw = 1; e.ifidf = 0; e.idexf = 0; e.exmemf = 0;
      if (s.pcsrc) begin
        e.ifidf = 1; e.idexf = 1; e.exmemf = 1; f_inc = 1;
      end else if (s.ex_jr) begin
        e.ifidf = 1; e.idexf = 1; f_inc = 1;
      end else if (lu) begin
        e.pcw = 0; e.ifidw = 0; e.idexf = 1; s_inc = 1;
      end else if (s.jump) begin
        e.ifidf = 1; f_inc = 1;
      end
    end
  endtask

  task automatic drive(input stim_t s, input string tag);
    exp_t e;
    bit   s_inc, f_inc;
    @(negedge Clk);
    Reset = s.reset; ID_Rs = s.id_rs; ID_Rt = s.id_rt; ID_UsesRs = s.uses_rs;
    ID_UsesRt = s.uses_rt; ID_Jump = s.jump; EX_Rs = s.ex_rs; EX_Rt = s.ex_rt;
    EX_MemRead = s.ex_memread; EX_Jr = s.ex_jr; EX_WriteReg = s.ex_wr;
    MEM_RegWrite = s.mem_rw; MEM_WriteReg = s.mem_wr; WB_RegWrite = s.wb_rw;
    WB_WriteReg = s.wb_wr; M_PCSrc = s.pcsrc;
    if (m_known) begin
      predict(s, tag, e, s_inc, f_inc);
      exp_q.push_back(e);
      if (s.reset) begin
        m_cyc = 0; m_stall = 0; m_flush = 0;
      end else begin
        if (m_cyc < INIT_CYCLES) m_cyc++;
        if (s_inc && m_stall < CNT_MAX) m_stall++;
        if (f_inc && m_flush < CNT_MAX) m_flush++;
      end
    end else if (s.reset) begin
      m_known = 1; m_cyc = 0; m_stall = 0; m_flush = 0;
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s = '0;
    s.id_rs = 5'($urandom_range(0, 3));  s.id_rt = 5'($urandom_range(0, 3));
    s.ex_rs = 5'($urandom_range(0, 3));  s.ex_rt = 5'($urandom_range(0, 3));
    s.ex_wr = 5'($urandom_range(0, 3));  s.mem_wr = 5'($urandom_range(0, 3));
    s.wb_wr = 5'($urandom_range(0, 3));
    s.uses_rs = 1'($urandom_range(0, 1)); s.uses_rt = 1'($urandom_range(0, 1));
    s.mem_rw  = 1'($urandom_range(0, 1)); s.wb_rw   = 1'($urandom_range(0, 1));
    s.ex_memread = ($urandom_range(0, 2) == 0);
    s.jump  = ($urandom_range(0, 5) == 0);
    s.ex_jr = ($urandom_range(0, 9) == 0);
    s.pcsrc = ($urandom_range(0, 9) == 0);
    s.reset = ($urandom_range(0, 199) == 0);
    return s;
  endfunction

  // Monitor: samples mid-cycle, well away from the posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (PCWrite !== e.pcw || IFID_Write !== e.ifidw || IFID_Flush !== e.ifidf ||
            IDEX_Flush !== e.idexf || EXMEM_Flush !== e.exmemf || InitDone !== e.done ||
            ForwardA !== e.fa || ForwardB !== e.fb ||
            StallCount !== CNT_W'(e.stall) || FlushCount !== CNT_W'(e.flush)) begin
          n_errors++;
          $display("FAIL %s t=%0t got pcw=%b ifidw=%b fl=%b%b%b done=%b fa=%b fb=%b st=%0d fc=%0d exp pcw=%b ifidw=%b fl=%b%b%b done=%b fa=%b fb=%b st=%0d fc=%0d",
                   e.tag, $time, PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush,
                   InitDone, ForwardA, ForwardB, StallCount, FlushCount,
                   e.pcw, e.ifidw, e.ifidf, e.idexf, e.exmemf, e.done, e.fa, e.fb,
                   e.stall, e.flush);
        end
      end
    end
  end

  initial begin
    stim_t s;
    stim_t idle;
    idle = '0;

    s = idle; s.reset = 1;
    drive(s, "reset");
    for (int i = 0; i < INIT_CYCLES + 2; i++) drive(idle, "init_seq");

    s = idle; s.ex_memread = 1; s.ex_wr = 5'd8; s.id_rs = 5'd8; s.uses_rs = 1;
    drive(s, "load_use");
    drive(idle, "after_stall");

    s = idle; s.ex_memread = 1; s.ex_wr = 5'd8; s.id_rt = 5'd8; s.uses_rt = 0;
    drive(s, "rt_not_used");
    s = idle; s.ex_memread = 1; s.ex_wr = 5'd0; s.id_rs = 5'd0; s.uses_rs = 1;
    drive(s, "lu_reg0");

    s = idle; s.mem_rw = 1; s.mem_wr = 5'd5; s.wb_rw = 1; s.wb_wr = 5'd5;
    s.ex_rs = 5'd5; s.ex_rt = 5'd5;
    drive(s, "fwd_mem_prio");
    s.mem_wr = 5'd0; s.wb_wr = 5'd0; s.ex_rs = 5'd0; s.ex_rt = 5'd0;
    drive(s, "fwd_reg0");
    s = idle; s.wb_rw = 1; s.wb_wr = 5'd7; s.ex_rt = 5'd7; s.ex_rs = 5'd6;
    drive(s, "fwd_wb");

    s = idle; s.pcsrc = 1; s.jump = 1; s.ex_memread = 1; s.ex_wr = 5'd3;
    s.id_rs = 5'd3; s.uses_rs = 1;
    drive(s, "branch_lu_jump");
    s.pcsrc = 0; s.ex_jr = 1;
    drive(s, "jr_over_lu");
    s.ex_jr = 0;
    drive(s, "lu_over_jump");
    s = idle; s.jump = 1;
    drive(s, "jump");

    for (int i = 0; i < 3000; i++) drive(rand_stim(), "random");

    s = idle; s.reset = 1;
    drive(s, "reset2");
    s = idle; s.jump = 1;
    for (int i = 0; i < 70000; i++) drive(s, "jump_saturate");

    s = idle; s.ex_memread = 1; s.ex_wr = 5'd9; s.id_rt = 5'd9; s.uses_rt = 1;
    drive(s, "stall_pre_reset");
    s.reset = 1;
    drive(s, "reset_in_stall");
    s.reset = 0;
    drive(s, "post_reset_init");
    for (int i = 0; i < INIT_CYCLES + 2; i++) drive(s, "reinit_then_stall");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
    @(negedge Clk);
    #4;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expected responses never compared, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipelined datapath: it generates the write-enables, flush signals and operand-forwarding selects that the pipeline registers and EX-stage operand muxes need for correct execution. It runs a post-reset initialisation sequence that flushes the pipeline registers, which have no reset of their own. In run mode it resolves load-use stalls, branch/jump/jr redirects and EX-stage forwarding. It keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- INIT_CYCLES, 4, number of post-reset cycles spent flushing the pipeline (legal range 1–15)
- CNT_W, 16, width of the stall and flush performance counters

Ports:
- Clk  in  1  single clock, all state updates on posedge
- Reset  in  1  synchronous, active-high
- ID_Rs, ID_Rt  in  5 each  source register numbers of the instruction in ID
- ID_UsesRs, ID_UsesRt  in  1 each  ID instruction actually reads Rs / Rt
- ID_Jump  in  1  j/jal decoded in ID
- EX_Rs, EX_Rt  in  5 each  source registers of the instruction in EX
- EX_MemRead  in  1  EX instruction is a load
- EX_Jr  in  1  jr resolving in EX
- EX_WriteReg  in  5  destination register of the EX instruction
- MEM_RegWrite  in  1; MEM_WriteReg  in  5  MEM-stage writeback info
- WB_RegWrite  in  1; WB_WriteReg  in  5  WB-stage writeback info
- M_PCSrc  in  1  branch taken, resolved in MEM
- PCWrite  out  1  PC update enable
- IFID_Write  out  1  IF/ID register load enable
- IFID_Flush, IDEX_Flush, EXMEM_Flush  out  1 each  load a bubble (all-zero controls) into that register
- ForwardA, ForwardB  out  2 each  EX operand select: 00 register file, 10 MEM ALU result, 01 WB write data
- InitDone  out  1  high once the run state is reached
- StallCount, FlushCount  out  CNT_W each  saturating performance counters

## Operation
- States: INIT, RUN. A 4-bit InitCnt is used only in INIT.
- INIT outputs: PCWrite=0, IFID_Write=1, all three flushes=1, ForwardA/B=00, InitDone=0. InitCnt increments each cycle. When InitCnt==INIT_CYCLES-1, the next state is RUN.
- RUN: InitDone=1. Forwarding is evaluated every cycle, independent of the stall and flush decisions.
  - ForwardA=10 if MEM_RegWrite && MEM_WriteReg!=0 && MEM_WriteReg==EX_Rs.
  - Otherwise ForwardA=01 if WB_RegWrite && WB_WriteReg!=0 && WB_WriteReg==EX_Rs.
  - Otherwise ForwardA=00.
  - ForwardB is identical, using EX_Rt.
- Load-use hazard LU = EX_MemRead && EX_WriteReg!=0 && ((ID_UsesRs && ID_Rs==EX_WriteReg) || (ID_UsesRt && ID_Rt==EX_WriteReg)).
- RUN default outputs: PCWrite=1, IFID_Write=1, all flushes=0. Overrides apply in strict priority order:
  1. M_PCSrc: IFID_Flush=IDEX_Flush=EXMEM_Flush=1. LU and jumps are ignored. FlushCount+1.
  2. EX_Jr: IFID_Flush=IDEX_Flush=1. FlushCount+1.
  3. LU: PCWrite=0, IFID_Write=0, IDEX_Flush=1. StallCount+1. ID_Jump is ignored this cycle and re-evaluated next cycle.
  4. ID_Jump: IFID_Flush=1. FlushCount+1.
- Counters saturate at all-ones and never wrap. Each counter increments at most once per cycle.

## Timing
- All outputs are combinational from the current inputs and state. The state, InitCnt and counters are registered.
- Reset (sampled at posedge) sets state=INIT, InitCnt=0, StallCount=0, FlushCount=0. The combinational outputs then take their INIT values.
- Reset asserted mid-run: the next cycle is INIT with all counters cleared, regardless of pending hazards.
- InitDone rises exactly INIT_CYCLES cycles after the Reset-deasserted edge.
- A load-use stall lasts exactly 1 cycle: the bubble clears EX_MemRead, so LU self-deasserts.
- A taken branch costs 3 squashed instructions; jr costs 2; j costs 1.
- Simultaneous M_PCSrc and LU: flush only, no stall, and StallCount unchanged.
- Register $0 never forwards and never causes a stall.

## Test plan
- Reset pulse with INIT_CYCLES=4 -> flushes=1 and PCWrite=0 for 4 cycles; InitDone=1 in cycle 5; counters 0.
- In RUN, EX lw writes $8 while ID add reads $8 as Rs -> 1 cycle with PCWrite=0, IFID_Write=0, IDEX_Flush=1; StallCount=1; next cycle normal.
- MEM writes $5 and WB writes $5, EX_Rs=5, EX_Rt=5 -> ForwardA=10, ForwardB=10. With MEM_WriteReg=0 and WB writing $0 -> both 00.
- M_PCSrc=1 with LU=1 and ID_Jump=1 in the same cycle -> all three flushes=1, PCWrite=1, FlushCount+1, StallCount unchanged.
- Force 70000 consecutive ID_Jump cycles (CNT_W=16) -> FlushCount holds at 65535 and does not wrap.
- Assert Reset during an active load-use stall -> next cycle in INIT with InitDone=0 and StallCount=0.
